// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM encoding and request legality check for the load/store unit.
package lsu_pkg;
  localparam int CPU_WIDTH = 32;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;
  function automatic logic lsu_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic ill, mis;
    ill = we ? (f3 >= 3'b011) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    mis = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    return ill || mis;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           off_i,
  input  logic [CPU_WIDTH-1:0] rdata_i,
  input  logic [CPU_WIDTH-1:0] wdata_i,
  output logic [CPU_WIDTH-1:0] load_o,
  output logic [CPU_WIDTH-1:0] merge_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata_i[8*off_i +: 8];
    h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o = funct3_i == F3_LB  ? {{24{b[7]}}, b} :
             funct3_i == F3_LBU ? {24'b0, b} :
             funct3_i == F3_LH  ? {{16{h[15]}}, h} :
             funct3_i == F3_LHU ? {16'b0, h} : rdata_i;
    merge_o = funct3_i == F3_SW ? wdata_i : rdata_i;
    if (funct3_i == F3_SB) merge_o[8*off_i +: 8] = wdata_i[7:0];
    if (funct3_i == F3_SH) merge_o[16*off_i[1] +: 16] = wdata_i[15:0];
  end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding RV32I load/store unit over a word-only data memory.
// Sub-word stores are done as read-modify-write; memory outputs depend on registered state only.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = CPU_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [CPU_WIDTH-1:0]  req_wdata_i,
  input  logic [4:0]            req_rd_i,
  output logic                  rsp_valid_o,
  output logic [CPU_WIDTH-1:0]  rsp_rdata_o,
  output logic [4:0]            rsp_rd_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_wr_en_o,
  output logic [CPU_WIDTH-1:0]  mem_wdata_o,
  input  logic [CPU_WIDTH-1:0]  mem_rdata_i
);
  state_e                state_q, state_d;
  logic                  we_q, we_d, err_q, err_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CPU_WIDTH-1:0]  wdata_q, wdata_d, merge_q, merge_d, rdata_q, rdata_d;
  logic [4:0]            rd_q, rd_d;
  logic [CPU_WIDTH-1:0]  load_w, merge_w;
  logic                  mem_active, resp;

  lsu_align u_align (
    .funct3_i(funct3_q),
    .off_i   (addr_q[1:0]),
    .rdata_i (mem_rdata_i),
    .wdata_i (wdata_q),
    .load_o  (load_w),
    .merge_o (merge_w)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    err_d    = err_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    case (state_q)
      ST_IDLE: if (req_valid_i) begin
        we_d     = req_we_i;
        funct3_d = req_funct3_i;
        addr_d   = req_addr_i;
        wdata_d  = req_wdata_i;
        rd_d     = req_rd_i;
        merge_d  = req_wdata_i;
        rdata_d  = '0;
        err_d    = lsu_err(req_we_i, req_funct3_i, req_addr_i[1:0]);
        state_d  = err_d ? ST_RESP : !req_we_i ? ST_LOAD : req_funct3_i == F3_SW ? ST_WRITE : ST_READ;
      end
      ST_LOAD: begin
        rdata_d = load_w;
        state_d = ST_RESP;
      end
      ST_READ: begin
        merge_d = merge_w;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      err_q    <= err_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
    end
  end

  // we_q only distinguishes the paths at accept; responses are fully described by rdata/err
  logic unused_we;
  assign unused_we   = we_q;
  assign mem_active  = state_q == ST_LOAD || state_q == ST_READ || state_q == ST_WRITE;
  assign resp        = state_q == ST_RESP;
  assign req_ready_o = state_q == ST_IDLE;
  assign rsp_valid_o = resp;
  assign rsp_rdata_o = resp ? rdata_q : '0;
  assign rsp_rd_o    = resp ? rd_q : '0;
  assign rsp_err_o   = resp & err_q;
  assign mem_addr_o  = mem_active ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wr_en_o = state_q == ST_WRITE;
  assign mem_wdata_o = state_q == ST_WRITE ? merge_q : '0;
endmodule
